eprisc_iobus_master: RTL and testbench
======================================

# eprisc_iobus_master

CPU-side initiator for the epRISC I/O controller byte bus. Accepts one 32-bit request word (write flag, 15-bit address, 16-bit data) from the host and serialises it onto the byte-parallel bus as six bus-clock pulses. The master generates the bus clock and the select lines, captures the four returned MISO bytes, and synchronises the controller interrupt. It sits between the CPU I/O port and the controller's iBusClock/iBusSelect/iBusMOSI/oBusMISO/oBusInterrupt pins.

## Interface
- pHalfDiv, 4: iClk cycles per bus-clock half-period; legal values are 1..255.
- pSelect, 2'h1: select code driven while a transaction is active. Must be nonzero.
- iClk  in  1  system clock; all logic is on its rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iStart  in  1  request; accepted on an iClk edge when iStart=1 and oBusy=0.
- iWrite  in  1  becomes word bit 31.
- iAddr  in  15  becomes word bits 30:16.
- iWrData  in  16  becomes word bits 15:0.
- oBusy  out  1  high from the accept edge until return to IDLE.
- oDone  out  1  one-cycle pulse; oRdData is valid from this pulse onward.
- oRdData  out  32  captured MISO word; byte0 occupies bits 7:0. Holds until the next oDone.
- oIrq  out  1  iBusInterrupt after a 2-flop synchroniser.
- oBusClock  out  1  bus clock to the controller.
- oBusSelect  out  2  pSelect during a transaction, 2'h0 otherwise. 2'h0 holds the controller pipeline in reset.
- oBusMOSI  out  8  outgoing byte.
- iBusMISO  in  8  returned byte.
- iBusInterrupt  in  1  asynchronous controller interrupt.

## Operation
- Reset values: oBusy=0, oDone=0, oRdData=0, oIrq=0, oBusClock=0, oBusSelect=0, oBusMOSI=0, state IDLE.
- Latched word W = {iWrite, iAddr, iWrData}. Bytes are sent LSB first: B0=W[7:0], B1=W[15:8], B2=W[23:16], B3=W[31:24].
- All outputs are registered. A half-period counter counts 0..pHalfDiv-1. An edge counter k counts 1..6.
- IDLE: clock low, select 0, MOSI 0. On accept, latch W and go to SETUP with oBusSelect=pSelect.
- SETUP: clock low for pHalfDiv cycles; the controller leaves reset and sits in its Load stage. Then go to HIGH with k=1.
- HIGH(k): oBusClock=1 for pHalfDiv cycles. On the entry edge:
  - for k=1..4, drive oBusMOSI=B(k-1);
  - for k=5..6, drive oBusMOSI=0;
  - for k=2..5, capture the pre-edge iBusMISO into oRdData byte k-2.
- LOW(k): oBusClock=0 for pHalfDiv cycles. The controller samples MOSI on this falling edge. At the end, go to HIGH(k+1) if k<6; otherwise pulse oDone and go to GAP.
- GAP: select 0 and clock low for pHalfDiv cycles; oBusy stays high. Then go to IDLE.
- The 6th rising edge is the controller's Store edge. For a write, the write commits there.
- Read data is the controller's combinational MISO at the time of capture. Because of address timing, it reflects the previously addressed register. The host issues a repeat read to fetch the current one; the master does not compensate.
- Address 7FFF with iWrite=1 is a controller soft reset. The master handles it as an ordinary transaction.
- iStart while oBusy=1 is ignored. Requests are not queued.
- iRst mid-transaction: all outputs return to reset values asynchronously. oBusSelect=0 also resets the controller pipeline. No oDone is issued and the request is lost.

## Timing
- Let H = pHalfDiv. The accept edge is cycle 0.
- oBusSelect rises at cycle 1.
- oBusClock rising edge k occurs at cycle 1+H+2H(k-1); the falling edge follows H cycles later.
- oDone pulses at cycle 1+13H. oBusy falls at cycle 1+14H.
- Next accept is possible at cycle 1+14H. Throughput is one transaction per 14H+1 cycles.
- MOSI setup to the capturing falling edge is H cycles. MISO is sampled H cycles after the controller state change.
- oIrq latency is 2 iClk cycles from a synchronous iBusInterrupt change.

## Configuration
- IOBUS_BURST_EN defined: if iStart=1 in the oDone cycle, the new word is latched in that cycle and GAP and SETUP are skipped.
  - oBusSelect stays at pSelect.
  - The next HIGH(1) follows directly after LOW(6).
  - Back-to-back period is 12H cycles, and oDone pulses once per transaction.
  - oBusy stays high across the burst.
- IOBUS_BURST_EN undefined: an iStart in the oDone cycle is ignored, and every transaction passes through GAP with select low.

## Test plan
- Write, H=2: iWrite=1, iAddr=0x0041, iWrData=0x1234 → MOSI at falling edges 1–4 is 34,12,41,80; exactly 6 rising edges; oDone at cycle 27; oBusy low at cycle 29.
- Read: bus model returns DE,AD,BE,EF in stages LoLo..HiHi → oRdData=0xEFBEADDE at oDone, held until the next oDone.
- iStart held high throughout a transaction (macro off) → exactly one transaction, then the next is accepted at cycle 1+14H with select low for H cycles between them.
- iRst pulsed after rising edge 3 → same cycle: oBusClock=0, oBusSelect=0, oBusMOSI=0; no oDone. A following write of 0x0040/0xBEEF completes normally.
- iBusInterrupt 0→1 → oIrq=1 two cycles later; returns to 0 two cycles after release.
- IOBUS_BURST_EN, H=1: two requests back-to-back → select never drops, 12 rising edges, second oDone 12 cycles after the first.

Source files
------------

// File: rtl/eprisc_iobus_master.sv
// eprisc_iobus_master: CPU-side initiator for the epRISC I/O controller byte bus.
// Serialises one 32-bit request word {write, addr[14:0], data[15:0]} as six
// bus-clock pulses and collects the four returned MISO bytes.
// Optional feature: define IOBUS_BURST_EN to chain requests without GAP/SETUP.
module eprisc_iobus_master #(
    parameter int unsigned pHalfDiv = 4,
    parameter logic [1:0]  pSelect  = 2'h1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic        iWrite,
    input  logic [14:0] iAddr,
    input  logic [15:0] iWrData,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oRdData,
    output logic        oIrq,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StGap
    } state_e;

    localparam logic [7:0] HalfLast = 8'(pHalfDiv - 1);
    localparam logic [2:0] LastEdge = 3'd6;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  edge_q, edge_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        bus_clk_q, bus_clk_d;
    logic [1:0]  bus_sel_q, bus_sel_d;
    logic [7:0]  mosi_q, mosi_d;
    logic        irq_meta_q, irq_q;

    logic        half_end;
    logic [2:0]  edge_next;

    // Byte driven on MOSI for rising edge k: word bytes LSB first, zero after the fourth.
    function automatic logic [7:0] tx_byte(input logic [31:0] word, input logic [2:0] k);
        case (k)
            3'd1:    return word[7:0];
            3'd2:    return word[15:8];
            3'd3:    return word[23:16];
            3'd4:    return word[31:24];
            default: return 8'h00;
        endcase
    endfunction

    assign half_end  = (cnt_q == HalfLast);
    assign edge_next = edge_q + 3'd1;

    // Next-state and registered-output logic for the bus sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = 8'd0;
        edge_d    = edge_q;
        word_d    = word_q;
        rd_buf_d  = rd_buf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        bus_clk_d = bus_clk_q;
        bus_sel_d = bus_sel_q;
        mosi_d    = mosi_q;

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    word_d    = {iWrite, iAddr, iWrData};
                    state_d   = StSetup;
                    busy_d    = 1'b1;
                    bus_sel_d = pSelect;
                end
            end

            // Select is up, clock low: controller leaves reset and sits in Load.
            StSetup: begin
                if (half_end) begin
                    state_d   = StHigh;
                    edge_d    = 3'd1;
                    bus_clk_d = 1'b1;
                    mosi_d    = tx_byte(word_q, 3'd1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StHigh: begin
                if (half_end) begin
                    state_d   = StLow;
                    bus_clk_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // Controller samples MOSI on the falling edge that opened this phase.
            StLow: begin
                if (half_end) begin
                    if (edge_q == LastEdge) begin
                        done_d    = 1'b1;
                        rd_data_d = rd_buf_q;
`ifdef IOBUS_BURST_EN
                        if (iStart) begin
                            // Chain straight into HIGH(1), select stays asserted.
                            word_d    = {iWrite, iAddr, iWrData};
                            state_d   = StHigh;
                            edge_d    = 3'd1;
                            bus_clk_d = 1'b1;
                            mosi_d    = iWrData[7:0];
                        end else begin
                            state_d   = StGap;
                            bus_sel_d = 2'h0;
                            mosi_d    = 8'h00;
                        end
`else
                        state_d   = StGap;
                        bus_sel_d = 2'h0;
                        mosi_d    = 8'h00;
`endif
                    end else begin
                        state_d   = StHigh;
                        edge_d    = edge_next;
                        bus_clk_d = 1'b1;
                        mosi_d    = tx_byte(word_q, edge_next);
                        // MISO just before rising edges 2..5 carries bytes 0..3.
                        case (edge_next)
                            3'd2:    rd_buf_d[7:0]   = iBusMISO;
                            3'd3:    rd_buf_d[15:8]  = iBusMISO;
                            3'd4:    rd_buf_d[23:16] = iBusMISO;
                            3'd5:    rd_buf_d[31:24] = iBusMISO;
                            default: ;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // Select low for a half period so the controller pipeline resets.
            StGap: begin
                if (half_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and registered bus/host outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            edge_q    <= 3'd0;
            word_q    <= 32'h0;
            rd_buf_q  <= 32'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 32'h0;
            bus_clk_q <= 1'b0;
            bus_sel_q <= 2'h0;
            mosi_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            word_q    <= word_d;
            rd_buf_q  <= rd_buf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            bus_clk_q <= bus_clk_d;
            bus_sel_q <= bus_sel_d;
            mosi_q    <= mosi_d;
        end
    end

    // Two-flop synchroniser for the asynchronous controller interrupt.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            irq_meta_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_meta_q <= iBusInterrupt;
            irq_q      <= irq_meta_q;
        end
    end

    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oRdData    = rd_data_q;
    assign oIrq       = irq_q;
    assign oBusClock  = bus_clk_q;
    assign oBusSelect = bus_sel_q;
    assign oBusMOSI   = mosi_q;

endmodule

// File: tb/tb_eprisc_iobus_master.sv
// Self-checking bench for eprisc_iobus_master. Cycle t counts iClk periods from the
// period in which the request is presented (t=0); outputs are sampled 1 ns after each edge.
`timescale 1ns/1ps
module tb_eprisc_iobus_master;
    localparam int unsigned H   = 2;
    localparam logic [1:0]  SEL = 2'h1;
    localparam int          TXN = 14 * H + 1;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iStart = 1'b0;
    logic        iWrite = 1'b0;
    logic [14:0] iAddr = '0;
    logic [15:0] iWrData = '0;
    logic        oBusy, oDone, oIrq, oBusClock;
    logic [31:0] oRdData;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO = '0;
    logic        iBusInterrupt = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_rd = '0;

    typedef struct packed {
        logic       clk;
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic [7:0] mosi;
        logic [2:0] nrise;
    } exp_t;

    eprisc_iobus_master #(.pHalfDiv(H), .pSelect(SEL)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iWrite(iWrite), .iAddr(iAddr),
        .iWrData(iWrData), .oBusy(oBusy), .oDone(oDone), .oRdData(oRdData), .oIrq(oIrq),
        .oBusClock(oBusClock), .oBusSelect(oBusSelect), .oBusMOSI(oBusMOSI),
        .iBusMISO(iBusMISO), .iBusInterrupt(iBusInterrupt)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Expected bus view at cycle t of a transaction on word w, from the timing rules:
    // rising edge k at 1+H+2H(k-1), each half lasting H, done at 1+13H, idle at 1+14H.
    function automatic exp_t model(int t, logic [31:0] w);
        exp_t e;
        int k;
        int ph;
        e = '0;
        e.sel  = (t >= 1 && t <= 13 * H) ? SEL : 2'h0;
        e.busy = (t >= 1 && t <= 14 * H);
        e.done = (t == 1 + 13 * H);
        if (t >= 1 + H && t < 1 + 13 * H) begin
            k  = (t - 1 - H) / (2 * H) + 1;
            ph = (t - 1 - H) % (2 * H);
            e.clk   = (ph < H);
            e.nrise = 3'(k);
            if (k <= 4) e.mosi = w[8*(k-1) +: 8];
        end else if (t >= 1 + 13 * H) begin
            e.nrise = 3'd6;
        end
        return e;
    endfunction

    // Bus-side controller stand-in: after rising edge n it presents returned byte n-1.
    function automatic logic [7:0] miso_for(logic [2:0] nrise, logic [31:0] r);
        if (nrise >= 3'd1 && nrise <= 3'd4) return r[8*(nrise-1) +: 8];
        return 8'($urandom);
    endfunction

    task automatic test_reset();
        #3;
        n_vec++;
        if ({oBusy, oDone, oIrq, oBusClock, oBusSelect, oBusMOSI, oRdData} !== '0) begin
            n_bad++;
            $display("FAIL reset_async outs=%h busy=%b sel=%h want all zero",
                     {oBusClock, oBusSelect, oBusMOSI}, oBusy, oBusSelect);
        end
        tick();
        iRst = 1'b0;
        tick();
        tick();
        n_vec++;
        if (oBusy !== 1'b0 || oDone !== 1'b0 || oBusClock !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle busy=%b done=%b clk=%b want 0 0 0", oBusy, oDone, oBusClock);
        end
        n_vec++;
        if (oBusSelect !== 2'h0 || oBusMOSI !== 8'h00 || oRdData !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus sel=%h mosi=%h rd=%h want 0 0 0", oBusSelect, oBusMOSI, oRdData);
        end
    endtask

    task automatic test_irq();
        iBusInterrupt = 1'b1;
        tick();
        n_vec++;
        if (oIrq !== 1'b0) begin n_bad++; $display("FAIL irq_rise_early got %b want 0", oIrq); end
        tick();
        n_vec++;
        if (oIrq !== 1'b1) begin n_bad++; $display("FAIL irq_rise got %b want 1", oIrq); end
        iBusInterrupt = 1'b0;
        tick();
        n_vec++;
        if (oIrq !== 1'b1) begin n_bad++; $display("FAIL irq_fall_early got %b want 1", oIrq); end
        tick();
        n_vec++;
        if (oIrq !== 1'b0) begin n_bad++; $display("FAIL irq_fall got %b want 0", oIrq); end
    endtask

    task automatic test_write();
        logic [7:0] got [4];
        logic [7:0] want [4];
        int rises = 0, falls = 0, done_t = -1, idle_t = -1;
        logic prev_clk;
        logic [7:0] prev_mosi;
        want = '{8'h34, 8'h12, 8'h41, 8'h80};
        got = '{8'h00, 8'h00, 8'h00, 8'h00};
        iStart = 1'b1; iWrite = 1'b1; iAddr = 15'h0041; iWrData = 16'h1234;
        iBusMISO = 8'hC3;
        prev_clk = oBusClock; prev_mosi = oBusMOSI;
        for (int t = 1; t <= TXN + 2; t++) begin
            tick();
            iStart = 1'b0;
            if (oBusClock && !prev_clk) rises++;
            if (!oBusClock && prev_clk) begin
                if (falls < 4) got[falls] = prev_mosi;
                falls++;
            end
            if (oDone && done_t < 0) done_t = t;
            if (!oBusy && idle_t < 0) idle_t = t;
            prev_clk = oBusClock; prev_mosi = oBusMOSI;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL write_mosi[%0d] got %h want %h", i, got[i], want[i]);
            end
        end
        n_vec++;
        if (rises != 6 || falls != 6) begin
            n_bad++; $display("FAIL write_edges rises=%0d falls=%0d want 6 6", rises, falls);
        end
        n_vec++;
        if (done_t != 1 + 13 * H) begin
            n_bad++; $display("FAIL write_done_cycle got %0d want %0d", done_t, 1 + 13 * H);
        end
        n_vec++;
        if (idle_t != 1 + 14 * H) begin
            n_bad++; $display("FAIL write_busy_low got %0d want %0d", idle_t, 1 + 14 * H);
        end
        exp_rd = 32'hC3C3C3C3;
        n_vec++;
        if (oRdData !== exp_rd) begin
            n_bad++; $display("FAIL write_rd got %h want %h", oRdData, exp_rd);
        end
    endtask

    task automatic test_read();
        logic [31:0] r = 32'hEFBEADDE;
        exp_t e;
        iStart = 1'b1; iWrite = 1'b0; iAddr = 15'($urandom); iWrData = 16'($urandom);
        for (int t = 1; t <= TXN; t++) begin
            tick();
            iStart = 1'b0;
            e = model(t, 32'h0);
            iBusMISO = miso_for(e.nrise, r);
            if (t == 13 * H) begin
                n_vec++;
                if (oRdData !== exp_rd) begin
                    n_bad++; $display("FAIL read_pre_done got %h want %h", oRdData, exp_rd);
                end
            end
            if (t == 1 + 13 * H) begin
                n_vec++;
                if (oDone !== 1'b1 || oRdData !== r) begin
                    n_bad++;
                    $display("FAIL read_at_done done=%b rd=%h want 1 %h", oDone, oRdData, r);
                end
            end
        end
        exp_rd = r;
        for (int i = 0; i < 5; i++) begin
            iBusMISO = 8'($urandom);
            tick();
            n_vec++;
            if (oRdData !== exp_rd) begin
                n_bad++; $display("FAIL read_hold got %h want %h", oRdData, exp_rd);
            end
        end
    endtask

`ifndef IOBUS_BURST_EN
    task automatic test_hold();
        int rises = 0, rises2 = 0, dones2 = 0;
        logic prev_clk;
        logic ok = 1'b0;
        iStart = 1'b1; iWrite = 1'b0; iAddr = 15'h0123; iWrData = 16'h4567;
        iBusMISO = 8'h96;
        prev_clk = oBusClock;
        for (int t = 1; t <= TXN; t++) begin
            tick();
            if (oBusClock && !prev_clk) rises++;
            prev_clk = oBusClock;
            if (t >= 1 + 13 * H) begin
                n_vec++;
                if (oBusSelect !== 2'h0) begin
                    n_bad++; $display("FAIL hold_gap_sel t=%0d got %h want 0", t, oBusSelect);
                end
            end
        end
        n_vec++;
        if (rises != 6 || oBusy !== 1'b0) begin
            n_bad++; $display("FAIL hold_first rises=%0d busy=%b want 6 0", rises, oBusy);
        end
        tick();
        iStart = 1'b0;
        n_vec++;
        if (oBusSelect !== SEL || oBusy !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_second_accept sel=%h busy=%b want %h 1", oBusSelect, oBusy, SEL);
        end
        prev_clk = oBusClock;
        for (int c = 0; c < TXN + 4; c++) begin
            tick();
            if (oBusClock && !prev_clk) rises2++;
            prev_clk = oBusClock;
            if (oDone) dones2++;
            if (!oBusy) begin ok = 1'b1; break; end
        end
        n_vec++;
        if (!ok || rises2 != 6 || dones2 != 1) begin
            n_bad++;
            $display("FAIL hold_second ended=%b rises=%0d dones=%0d want 1 6 1", ok, rises2, dones2);
        end
        exp_rd = 32'h96969696;
        n_vec++;
        if (oRdData !== exp_rd) begin
            n_bad++; $display("FAIL hold_rd got %h want %h", oRdData, exp_rd);
        end
    endtask
`endif

`ifdef IOBUS_BURST_EN
    task automatic test_burst();
        logic [31:0] w1, w2;
        int rises = 0, sel_drop = 0;
        int dones[$];
        logic prev_clk;
        w1 = $urandom; w2 = $urandom;
        iStart = 1'b1; {iWrite, iAddr, iWrData} = w1;
        prev_clk = oBusClock;
        for (int t = 1; t <= 1 + 26 * H; t++) begin
            tick();
            if (t == 1 || t == 13 * H + 1) iStart = 1'b0;
            if (t == 13 * H) begin iStart = 1'b1; {iWrite, iAddr, iWrData} = w2; end
            if (oBusClock && !prev_clk) rises++;
            prev_clk = oBusClock;
            if (t <= 25 * H && oBusSelect !== SEL) sel_drop++;
            if (oDone) dones.push_back(t);
        end
        n_vec++;
        if (sel_drop != 0 || rises != 12) begin
            n_bad++; $display("FAIL burst_bus drops=%0d rises=%0d want 0 12", sel_drop, rises);
        end
        n_vec++;
        if (dones.size() != 2) begin
            n_bad++; $display("FAIL burst_done_count got %0d want 2", dones.size());
        end else if (dones[0] != 1 + 13 * H || dones[1] - dones[0] != 12 * H) begin
            n_bad++;
            $display("FAIL burst_done_spacing got %0d,%0d want %0d,%0d",
                     dones[0], dones[1], 1 + 13 * H, 1 + 25 * H);
        end
        n_vec++;
        if (oBusy !== 1'b0) begin n_bad++; $display("FAIL burst_end busy=%b want 0", oBusy); end
        exp_rd = oRdData;
    endtask
`endif

    task automatic test_reset_mid();
        int done_seen = 0, busy_seen = 0, falls = 0;
        logic prev_clk;
        logic [7:0] prev_mosi;
        logic [7:0] got [4];
        logic [7:0] want [4];
        want = '{8'hEF, 8'hBE, 8'h40, 8'h80};
        got = '{8'h00, 8'h00, 8'h00, 8'h00};
        iStart = 1'b1; iWrite = 1'b0; iAddr = 15'($urandom); iWrData = 16'($urandom);
        for (int t = 1; t <= 1 + 5 * H; t++) begin
            tick();
            iStart = 1'b0;
            iBusMISO = 8'($urandom);
        end
        n_vec++;
        if (oBusClock !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_edge3 clk=%b want 1", oBusClock);
        end
        #2 iRst = 1'b1;
        #1;
        exp_rd = 32'h0;
        n_vec++;
        if (oBusClock !== 1'b0 || oBusSelect !== 2'h0 || oBusMOSI !== 8'h00) begin
            n_bad++;
            $display("FAIL rstmid_bus clk=%b sel=%h mosi=%h want 0 0 0",
                     oBusClock, oBusSelect, oBusMOSI);
        end
        n_vec++;
        if (oBusy !== 1'b0 || oRdData !== exp_rd) begin
            n_bad++; $display("FAIL rstmid_host busy=%b rd=%h want 0 0", oBusy, oRdData);
        end
        #1 iRst = 1'b0;
        tick();
        for (int c = 0; c < TXN + 4; c++) begin
            if (oDone) done_seen++;
            if (oBusy) busy_seen++;
            tick();
        end
        n_vec++;
        if (done_seen != 0 || busy_seen != 0) begin
            n_bad++;
            $display("FAIL rstmid_quiet dones=%0d busy_cycles=%0d want 0 0", done_seen, busy_seen);
        end
        // Recovery write 0x0040 / 0xBEEF completes normally.
        iStart = 1'b1; iWrite = 1'b1; iAddr = 15'h0040; iWrData = 16'hBEEF;
        iBusMISO = 8'h5A;
        done_seen = 0;
        prev_clk = oBusClock; prev_mosi = oBusMOSI;
        for (int t = 1; t <= TXN; t++) begin
            tick();
            iStart = 1'b0;
            if (!oBusClock && prev_clk) begin
                if (falls < 4) got[falls] = prev_mosi;
                falls++;
            end
            if (oDone) done_seen++;
            prev_clk = oBusClock; prev_mosi = oBusMOSI;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (got[i] !== want[i]) begin
                n_bad++; $display("FAIL recover_mosi[%0d] got %h want %h", i, got[i], want[i]);
            end
        end
        exp_rd = 32'h5A5A5A5A;
        n_vec++;
        if (done_seen != 1 || falls != 6 || oBusy !== 1'b0 || oRdData !== exp_rd) begin
            n_bad++;
            $display("FAIL recover_end dones=%0d falls=%0d busy=%b rd=%h want 1 6 0 %h",
                     done_seen, falls, oBusy, oRdData, exp_rd);
        end
    endtask

    task automatic test_random(int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w, r;
            int gap;
            exp_t e;
            w = $urandom; r = $urandom; gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                n_vec++;
                if (oBusy !== 1'b0 || oBusSelect !== 2'h0 || oBusClock !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_idle busy=%b sel=%h clk=%b want 0 0 0",
                             oBusy, oBusSelect, oBusClock);
                end
                tick();
            end
            iStart = 1'b1; {iWrite, iAddr, iWrData} = w;
            iBusMISO = 8'($urandom);
            for (int t = 1; t <= TXN; t++) begin
                tick();
                iStart = 1'b0;
                e = model(t, w);
                iBusMISO = miso_for(e.nrise, r);
                if (t == 1 + 13 * H) exp_rd = r;
                n_vec++;
                if (oBusClock !== e.clk || oBusSelect !== e.sel) begin
                    n_bad++;
                    $display("FAIL rand_bus w=%h t=%0d clk=%b sel=%h want %b %h",
                             w, t, oBusClock, oBusSelect, e.clk, e.sel);
                end
                n_vec++;
                if (oBusMOSI !== e.mosi) begin
                    n_bad++;
                    $display("FAIL rand_mosi w=%h t=%0d got %h want %h", w, t, oBusMOSI, e.mosi);
                end
                n_vec++;
                if (oBusy !== e.busy || oDone !== e.done) begin
                    n_bad++;
                    $display("FAIL rand_hs w=%h t=%0d busy=%b done=%b want %b %b",
                             w, t, oBusy, oDone, e.busy, e.done);
                end
                n_vec++;
                if (oRdData !== exp_rd) begin
                    n_bad++;
                    $display("FAIL rand_rd w=%h t=%0d got %h want %h", w, t, oRdData, exp_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_write();
        test_read();
`ifdef IOBUS_BURST_EN
        test_burst();
`else
        test_hold();
`endif
        test_reset_mid();
        test_random(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
